tma_perf_counters: RTL

TMA_PERF_COUNTERS -- requirements
Module: tma_perf_counters

---
 rtl/tma_perf_counters.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/tma_perf_counters.sv
// Top-down performance counters: per-slot issue/frontend/backend/flush-recovery
// classification with saturating live counters, snapshot shadows and a registered read port.
module tma_perf_counters #(
   parameter int SLOTS     = 2,
   parameter int RET_W     = 2,
   parameter int CNT_W     = 48,
   parameter int RECOV_CYC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clear_i,
   input  logic             snap_i,
   input  logic             halt_i,
   input  logic [SLOTS-1:0] dec_vld_i,
   input  logic             be_stall_i,
   input  logic             flush_i,
   input  logic [RET_W-1:0] ret_vld_i,
   input  logic [2:0]       rd_sel_i,
   output logic [CNT_W-1:0] rd_data_o,
   output logic             ovf_o,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      HALTED = 2'b10
   } state_t;

   localparam int N_CNT   = 7;
   localparam int C_TOTAL = 0;
   localparam int C_INSTR = 1;
   localparam int C_RET   = 2;
   localparam int C_FE    = 3;
   localparam int C_BE    = 4;
   localparam int C_FR    = 5;
   localparam int C_CYC   = 6;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [3:0]       inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {{(CNT_W-3){1'b0}}, inc};
      return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
   endfunction

   state_t           state_q, state_d;
   logic [3:0]       timer_q;
   logic             counting;
   logic             recov;
   logic             sat_any;
   logic [3:0]       inc      [N_CNT];
   logic [CNT_W-1:0] live_q   [N_CNT];
   logic [CNT_W-1:0] live_nxt [N_CNT];
   logic [CNT_W-1:0] shadow_q [N_CNT];
   logic [CNT_W-1:0] bad_spec;
   logic [CNT_W-1:0] rd_mux;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en_i) state_d = RUN;
         RUN: begin
            if (halt_i)     state_d = HALTED;
            else if (!en_i) state_d = IDLE;
         end
         HALTED:  if (clear_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign state_o = state_q;

   // Slot classification; a flush cycle or a live recovery window outranks backend stall for empty slots.
   always_comb begin
      counting = (state_q == RUN);
      recov    = flush_i || (timer_q != 4'd0);
      for (int i = 0; i < N_CNT; i++) inc[i] = 4'd0;
      inc[C_TOTAL] = 4'(SLOTS);
      inc[C_CYC]   = 4'd1;
      for (int s = 0; s < SLOTS; s++) begin
         if (dec_vld_i[s]) begin
            if (be_stall_i) inc[C_BE]    = inc[C_BE] + 4'd1;
            else            inc[C_INSTR] = inc[C_INSTR] + 4'd1;
         end else if (recov) begin
            inc[C_FR] = inc[C_FR] + 4'd1;
         end else if (be_stall_i) begin
            inc[C_BE] = inc[C_BE] + 4'd1;
         end else begin
            inc[C_FE] = inc[C_FE] + 4'd1;
         end
      end
      for (int r = 0; r < RET_W; r++) begin
         if (ret_vld_i[r]) inc[C_RET] = inc[C_RET] + 4'd1;
      end
   end

   always_comb begin
      sat_any = 1'b0;
      for (int i = 0; i < N_CNT; i++) begin
         live_nxt[i] = counting ? sat_add(live_q[i], inc[i]) : live_q[i];
         if (counting && (live_nxt[i] == CNT_MAX)) sat_any = 1'b1;
      end
   end

   // Shadows take the post-increment value, so snap with clear sees the pre-clear total.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CNT; i++) begin
            live_q[i]   <= '0;
            shadow_q[i] <= '0;
         end
         ovf_o   <= 1'b0;
         timer_q <= 4'd0;
      end else begin
         for (int i = 0; i < N_CNT; i++) begin
            live_q[i] <= clear_i ? '0 : live_nxt[i];
            if (snap_i) shadow_q[i] <= live_nxt[i];
         end
         if (clear_i)      ovf_o <= 1'b0;
         else if (sat_any) ovf_o <= 1'b1;
         if (clear_i)                timer_q <= 4'd0;
         else if (flush_i)           timer_q <= 4'(RECOV_CYC);
         else if (timer_q != 4'd0)   timer_q <= timer_q - 4'd1;
      end
   end

   assign bad_spec = (shadow_q[C_INSTR] > shadow_q[C_RET]) ?
                     (shadow_q[C_INSTR] - shadow_q[C_RET]) : '0;

   always_comb begin
      rd_mux = '0;
      case (rd_sel_i)
         3'd0: rd_mux = shadow_q[C_TOTAL];
         3'd1: rd_mux = shadow_q[C_INSTR];
         3'd2: rd_mux = shadow_q[C_RET];
         3'd3: rd_mux = shadow_q[C_FE];
         3'd4: rd_mux = shadow_q[C_BE];
         3'd5: rd_mux = shadow_q[C_FR];
         3'd6: rd_mux = bad_spec;
         3'd7: rd_mux = shadow_q[C_CYC];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) rd_data_o <= '0;
      else     rd_data_o <= rd_mux;
   end

endmodule
